// File: rtl/mem_bank.sv
// mem_bank: single-port, byte-maskable synchronous memory with a valid/ready
// request port, a self-clearing init sweep and a 1- or 2-cycle read pipeline.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   valid_i      request valid
//   ready_o      request can be accepted (high once the init sweep is done)
//   rd_wr_i      1 = write, 0 = read
//   addr_i       word address
//   wdata_i      write data
//   be_i         byte-lane write enables
//   rdata_o      read data, valid with rvalid_o, held otherwise
//   rvalid_o     one-cycle read-data strobe
//   err_o        one-cycle out-of-range access flag
//   init_done_o  init sweep complete
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | sweep writes INIT_VAL to word r_init_cnt, one word per cycle
// ST_READY | requests accepted every cycle, no backpressure

module mem_bank #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       DEPTH      = 16,
  parameter int unsigned       ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned       RD_LAT     = 1,
  parameter logic [WIDTH-1:0]  INIT_VAL   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  rd_wr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    be_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o,
  output logic                  init_done_o
);

  localparam int unsigned NB = WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic [ADDR_WIDTH-1:0] w_init_cnt_nxt;
  logic                  r_rdy;
  logic                  w_rdy_nxt;
  logic                  w_init_we;

  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_in_range;

  logic                  r_req_rd;
  logic                  r_req_oor;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_wr_err;

  logic [WIDTH-1:0]      w_rd_word;
  logic                  w_out_vld;
  logic                  w_out_rerr;
  logic [WIDTH-1:0]      w_out_data;

  logic [WIDTH-1:0]      r_rdata;
  logic                  r_rvalid;
  logic                  r_err;

  // ---------------------------------------------------------------------
  // Init / ready FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_rdy      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_rdy      <= w_rdy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_rdy_nxt      = r_rdy;
    w_init_we      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        if (r_init_cnt == LAST_IDX) begin
          w_state_nxt = ST_READY;
          w_rdy_nxt   = 1'b1;
        end else begin
          w_init_cnt_nxt = r_init_cnt + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        w_rdy_nxt = 1'b1;
      end
      default: begin
        w_state_nxt    = ST_INIT;
        w_init_cnt_nxt = '0;
        w_rdy_nxt      = 1'b0;
      end
    endcase
  end

  assign ready_o     = r_rdy;
  assign init_done_o = r_rdy;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  // r_rdy is only ever high in ST_READY, so it doubles as the accept gate.
  assign w_accept   = valid_i & r_rdy;
  assign w_in_range = (32'(addr_i) < DEPTH);

  // ---------------------------------------------------------------------
  // Storage array (not reset; the sweep owns initialisation)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_init_we) begin
      r_mem[r_init_cnt] <= INIT_VAL;
    end else if (w_accept && rd_wr_i && w_in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) begin
          r_mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Request stage: captures the accepted request. The array is read one
  // edge later, so a write committed at acceptance is already visible to
  // a read accepted on the following cycle without any bypass path.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_rd   <= 1'b0;
      r_req_oor  <= 1'b0;
      r_req_addr <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_req_rd <= w_accept & ~rd_wr_i;
      r_wr_err <= w_accept & rd_wr_i & ~w_in_range;
      if (w_accept) begin
        r_req_oor  <= ~w_in_range;
        r_req_addr <= addr_i;
      end
    end
  end

  assign w_rd_word = r_req_oor ? '0 : r_mem[r_req_addr];

  // ---------------------------------------------------------------------
  // Optional extra read stage
  // ---------------------------------------------------------------------
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             r_p_vld;
      logic             r_p_rerr;
      logic [WIDTH-1:0] r_p_data;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_p_vld  <= 1'b0;
          r_p_rerr <= 1'b0;
          r_p_data <= '0;
        end else begin
          r_p_vld  <= r_req_rd;
          r_p_rerr <= r_req_rd & r_req_oor;
          if (r_req_rd) begin
            r_p_data <= w_rd_word;
          end
        end
      end

      assign w_out_vld  = r_p_vld;
      assign w_out_rerr = r_p_rerr;
      assign w_out_data = r_p_data;
    end else begin : g_lat1
      assign w_out_vld  = r_req_rd;
      assign w_out_rerr = r_req_rd & r_req_oor;
      assign w_out_data = w_rd_word;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output registers. A write error (one stage old) and a read error
  // (RD_LAT stages old) can land on the same edge; they share one pulse.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_out_vld;
      r_err    <= w_out_rerr | r_wr_err;
      if (w_out_vld) begin
        r_rdata <= w_out_data;
      end
    end
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;

endmodule

// File: tb/tb_mem_bank.sv
module tb_mem_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: DEPTH 16, RD_LAT 2. Instance B: DEPTH 12, RD_LAT 1.
  logic        a_valid, a_wr, a_ready, a_rvalid, a_err, a_done;
  logic [3:0]  a_addr, a_be;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_wr, b_ready, b_rvalid, b_err, b_done;
  logic [3:0]  b_addr, b_be;
  logic [31:0] b_wdata, b_rdata;

  localparam logic [31:0] INIT_A = 32'hA5A5_A5A5;
  localparam logic [31:0] INIT_B = 32'h5A5A_0F0F;

  mem_bank #(.WIDTH(32), .DEPTH(16), .RD_LAT(2), .INIT_VAL(INIT_A)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .ready_o(a_ready),
    .rd_wr_i(a_wr), .addr_i(a_addr), .wdata_i(a_wdata), .be_i(a_be),
    .rdata_o(a_rdata), .rvalid_o(a_rvalid), .err_o(a_err), .init_done_o(a_done)
  );

  mem_bank #(.WIDTH(32), .DEPTH(12), .RD_LAT(1), .INIT_VAL(INIT_B)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .ready_o(b_ready),
    .rd_wr_i(b_wr), .addr_i(b_addr), .wdata_i(b_wdata), .be_i(b_be),
    .rdata_o(b_rdata), .rvalid_o(b_rvalid), .err_o(b_err), .init_done_o(b_done)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          sel_b;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit sel_b, input bit wr, input logic [3:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.sel_b = sel_b; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.be = be; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive(input bit sel_b, input bit v, input bit wr, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (sel_b) begin
      b_valid = v; b_wr = wr; b_addr = addr; b_wdata = wdata; b_be = be;
    end else begin
      a_valid = v; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be;
    end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  // Caller sits 1 time unit after a rising edge. The request is accepted on
  // the next edge; every following edge up to RD_LAT+1 is checked.
  task automatic xact(input vec_t v, input string name);
    int lat;
    int err_cyc;
    lat     = v.sel_b ? 1 : 2;
    err_cyc = v.wr ? 1 : lat;
    drive(v.sel_b, 1'b1, v.wr, v.addr, v.wdata, v.be);
    @(posedge clk); #1;
    drive(v.sel_b, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      chk({name, " rvalid"}, v.sel_b ? b_rvalid : a_rvalid, 32'(!v.wr && k == lat));
      chk({name, " err"}, v.sel_b ? b_err : a_err, 32'(v.exp_err && k == err_cyc));
      if (!v.wr && k >= lat)
        chk({name, " rdata"}, v.sel_b ? b_rdata : a_rdata, v.exp_rdata);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " a_ready"}, a_ready, 0);
    chk({name, " a_done"}, a_done, 0);
    chk({name, " a_rvalid"}, a_rvalid, 0);
    chk({name, " a_err"}, a_err, 0);
    chk({name, " a_rdata"}, a_rdata, 0);
    chk({name, " b_ready"}, b_ready, 0);
    chk({name, " b_done"}, b_done, 0);
    chk({name, " b_rvalid"}, b_rvalid, 0);
    chk({name, " b_err"}, b_err, 0);
    chk({name, " b_rdata"}, b_rdata, 0);
  endtask

  // Released at a falling edge; edge k is the k-th rising edge after release.
  task automatic release_and_sweep(input string name, input int edges);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s a_ready@%0d", name, k), a_ready, 32'(k >= 16));
      chk($sformatf("%s a_done@%0d", name, k), a_done, 32'(k >= 16));
      chk($sformatf("%s b_ready@%0d", name, k), b_ready, 32'(k >= 12));
      chk($sformatf("%s a_rvalid@%0d", name, k), a_rvalid, 0);
    end
  endtask

  initial begin
    logic [31:0] exp_d;
    rst_n = 1'b0;
    idle_all();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Init sweep timing
    release_and_sweep("init", 17);

    // Table-driven single transactions
    for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 0, 4'(i), 0, 0, INIT_A, 0));
    vecs.push_back(mk(0, 1, 4'd3, 32'h1122_3344, 4'hF, 0, 0));
    vecs.push_back(mk(0, 1, 4'd3, 32'hFFFF_FFFF, 4'b0101, 0, 0));
    vecs.push_back(mk(0, 0, 4'd3, 0, 0, 32'h11FF_33FF, 0));
    vecs.push_back(mk(0, 1, 4'd3, 32'h0000_0000, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd3, 0, 0, 32'h11FF_33FF, 0));
    vecs.push_back(mk(0, 1, 4'd7, 32'hCAFE_F00D, 4'b0011, 0, 0));
    vecs.push_back(mk(0, 0, 4'd7, 0, 0, 32'hA5A5_F00D, 0));
    vecs.push_back(mk(1, 0, 4'd0, 0, 0, INIT_B, 0));
    vecs.push_back(mk(1, 1, 4'd13, 32'h1234_5678, 4'hF, 0, 1));
    vecs.push_back(mk(1, 1, 4'd12, 32'h0000_0000, 4'hF, 0, 1));
    vecs.push_back(mk(1, 0, 4'd14, 0, 0, 32'h0, 1));
    for (int i = 0; i < 12; i++) vecs.push_back(mk(1, 0, 4'(i), 0, 0, INIT_B, 0));
    vecs.push_back(mk(1, 1, 4'd11, 32'hAB00_0000, 4'b1000, 0, 0));
    vecs.push_back(mk(1, 0, 4'd11, 0, 0, 32'hAB5A_0F0F, 0));
    vecs.push_back(mk(1, 0, 4'd15, 0, 0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 4'd11, 0, 0, 32'hAB5A_0F0F, 0));

    foreach (vecs[i]) xact(vecs[i], $sformatf("vec%0d", i));

    // Pipelined reads on A: three writes then three back-to-back reads
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 4'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 4'(i), 0, 0);
      @(posedge clk); #1;
      if (i < 2) chk($sformatf("pipe early rvalid%0d", i), a_rvalid, 0);
    end
    idle_all();
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("pipe rvalid%0d", j), a_rvalid, 32'(j < 3));
      chk($sformatf("pipe err%0d", j), a_err, 0);
      exp_d = 32'hC0DE_0000 + 32'((j < 3) ? j : 2);
      chk($sformatf("pipe rdata%0d", j), a_rdata, exp_d);
      @(posedge clk); #1;
    end

    // Write/read turnaround on A (RD_LAT 2)
    drive(0, 1, 1, 4'd5, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    drive(0, 1, 0, 4'd5, 0, 0);
    @(posedge clk); #1;
    idle_all();
    chk("ta_a rvalid n+1", a_rvalid, 0);
    @(posedge clk); #1;
    chk("ta_a rvalid n+2", a_rvalid, 0);
    @(posedge clk); #1;
    chk("ta_a rvalid n+3", a_rvalid, 1);
    chk("ta_a rdata", a_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Write/read turnaround on B (RD_LAT 1)
    drive(1, 1, 1, 4'd4, 32'h0BAD_F00D, 4'hF);
    @(posedge clk); #1;
    drive(1, 1, 0, 4'd4, 0, 0);
    @(posedge clk); #1;
    idle_all();
    chk("ta_b rvalid n+1", b_rvalid, 0);
    @(posedge clk); #1;
    chk("ta_b rvalid n+2", b_rvalid, 1);
    chk("ta_b rdata", b_rdata, 32'h0BAD_F00D);
    @(posedge clk); #1;

    // Reset one cycle after an A read: pulse must never appear
    drive(0, 1, 0, 4'd1, 0, 0);
    @(posedge clk); #1;
    idle_all();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_rd");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_rd hold rvalid%0d", k), a_rvalid, 0);
    end
    release_and_sweep("rst_rd", 16);

    // Reset mid-sweep at count 7
    rst_n = 1'b0;
    #1;
    chk_all_zero("pre_sweep");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_sweep");
    @(posedge clk); #1;
    release_and_sweep("resweep", 17);

    // Sweep overwrote earlier data
    xact(mk(0, 0, 4'd5, 0, 0, INIT_A, 0), "post a5");
    xact(mk(0, 0, 4'd3, 0, 0, INIT_A, 0), "post a3");
    xact(mk(1, 0, 4'd4, 0, 0, INIT_B, 0), "post b4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bank.md
# mem_bank

Parametrised single-port, byte-maskable synchronous memory with valid/ready request handshake, a self-clearing initialisation engine, and a configurable read pipeline. It replaces the fixed 8x16 register memory for scratchpad and configuration storage. It is sized per instance for width, depth and read latency, and it reports accesses to unmapped addresses.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8
- DEPTH, 16, number of words; any value ≥ 2, power of two not required
- ADDR_WIDTH, $clog2(DEPTH), address width
- RD_LAT, 1, read latency in cycles after acceptance; legal values 1 or 2
- INIT_VAL, 0, WIDTH-bit value written to every word by the init engine

- clk_i  input  1  clock; all logic on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- valid_i  input  1  request valid
- ready_o  output  1  block can accept a request this cycle
- rd_wr_i  input  1  1 = write, 0 = read
- addr_i  input  ADDR_WIDTH  word address
- wdata_i  input  WIDTH  write data
- be_i  input  WIDTH/8  byte-lane write enables; bit k covers wdata_i[8k+7:8k]
- rdata_o  output  WIDTH  read data; valid when rvalid_o = 1
- rvalid_o  output  1  one-cycle pulse marking rdata_o valid
- err_o  output  1  one-cycle pulse flagging an out-of-range access
- init_done_o  output  1  high once the init sweep has completed

## Operation
- States: INIT, READY.
- Reset (rst_ni = 0, asynchronous):
  - Force INIT with the init counter at 0.
  - ready_o, rvalid_o, err_o, init_done_o and rdata_o = 0.
  - Discard all in-flight reads.
  - The array is not reset directly.
- INIT:
  - One word per cycle, mem[cnt] <= INIT_VAL, with cnt running 0..DEPTH-1.
  - ready_o = 0. valid_i is ignored.
  - After the write of DEPTH-1, move to READY with init_done_o = 1 and ready_o = 1.
- READY:
  - ready_o = 1 every cycle. No backpressure.
  - A request is accepted on a rising edge when valid_i = 1 and ready_o = 1.
- Write accepted, addr_i < DEPTH:
  - Lanes with be_i[k] = 1 take wdata_i. Other lanes keep their contents.
  - be_i = 0 is a legal no-op.
  - No rvalid_o pulse.
- Read accepted, addr_i < DEPTH:
  - rdata_o = mem[addr_i], with a rvalid_o pulse RD_LAT cycles after acceptance.
- Out-of-range access (addr_i ≥ DEPTH; only possible when DEPTH is not a power of two):
  - Write: the array is unchanged, and err_o pulses 1 cycle after acceptance.
  - Read: rdata_o = 0 and rvalid_o pulses at the normal latency, with err_o pulsing in the same cycle.
- Reads are fully pipelined: back-to-back reads give back-to-back rvalid_o pulses in request order.
- rdata_o holds its last value when rvalid_o = 0.
- Read-after-write to the same address on consecutive cycles returns the newly written data, with masked lanes merged.
- Reset asserted mid-sweep or mid-read: the sweep restarts from 0 after release, and pending rvalid_o pulses are never emitted.

## Timing
- INIT starts on the first rising edge after rst_ni deasserts.
- init_done_o and ready_o rise DEPTH rising edges after reset release; both are registered.
- Read accepted at edge N:
  - RD_LAT = 1: rdata_o and rvalid_o are updated at edge N+1.
  - RD_LAT = 2: rdata_o and rvalid_o are updated at edge N+2.
- A write accepted at edge N is visible to a read accepted at edge N+1.
- err_o:
  - Write: updated at edge N+1.
  - Read: aligned with that read's rvalid_o.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Init sweep (DEPTH = 16, INIT_VAL = 32'hA5A5_A5A5, release reset): ready_o = 0 for 16 cycles, then 1; reading all 16 addresses returns A5A5_A5A5.
- Byte-mask merge: write 32'h1122_3344 with be_i = 4'hF to addr 3, then 32'hFFFF_FFFF with be_i = 4'b0101, then read addr 3 -> rdata_o = 32'h11FF_33FF.
- Pipelined reads (RD_LAT = 2): reads of addrs 0, 1, 2 on consecutive cycles -> three consecutive rvalid_o pulses 2 cycles later, data in order, err_o = 0.
- Out-of-range (DEPTH = 12):
  - Write to addr 13 -> err_o pulses 1 cycle later, and all 12 words are unchanged.
  - Read of addr 14 -> rdata_o = 0 with err_o and rvalid_o pulsing together.
- Reset mid-operation: assert rst_ni = 0 one cycle after a RD_LAT = 2 read, and again at sweep count 7 -> rvalid_o never pulses, all outputs are 0 immediately, and the sweep restarts and completes 16 cycles after release.
- Write/read turnaround: write 32'hDEAD_BEEF to addr 5, then read addr 5 on the next cycle -> DEAD_BEEF with RD_LAT latency.
